// File: rtl/cpu_ctrl_if.sv
// Bus bundle between the instruction sequencer and its neighbours:
// the program counter, the byte-wide synchronous memory and the ALU.
// The master side is the sequencer. The slave side is the CPU top level
// (or a bench) that hosts pc, mem and alu.
interface cpu_ctrl_if;
  // program counter
  logic [15:0] pc_addr;
  logic [1:0]  pc_op;
  logic [7:0]  pc_k;
  // shared memory
  logic [15:0] mem_addr;
  logic        mem_rw;
  logic [7:0]  mem_data;
  logic [7:0]  mem_q;
  // ALU
  logic [3:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_flags;
  logic [7:0]  alu_c;
  logic [7:0]  alu_new_flags;

  modport master (
    input  pc_addr, mem_q, alu_c, alu_new_flags,
    output pc_op, pc_k, mem_addr, mem_rw, mem_data,
           alu_op, alu_a, alu_b, alu_flags
  );

  modport slave (
    output pc_addr, mem_q, alu_c, alu_new_flags,
    input  pc_op, pc_k, mem_addr, mem_rw, mem_data,
           alu_op, alu_a, alu_b, alu_flags
  );
endinterface

// File: rtl/cpu_ctrl.sv
// Instruction sequencer for the 8-bit von Neumann CPU.
// Each instruction is two bytes, {opcode, rd, rs} followed by k. Both bytes
// are fetched over the shared synchronous memory (F0/F1/F2) and then
// executed in EX. LD needs one extra cycle (LDW) to collect the read data.
// The block owns the 4x8 register file and the flags register.
module cpu_ctrl #(
  parameter logic [7:0] DATA_PAGE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  cpu_ctrl_if.master bus,
  output logic       halted
);

  typedef enum logic [2:0] {
    ST_F0   = 3'd0,
    ST_F1   = 3'd1,
    ST_F2   = 3'd2,
    ST_EX   = 3'd3,
    ST_LDW  = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  localparam logic [1:0] PC_RESET   = 2'b00;
  localparam logic [1:0] PC_NOTHING = 2'b01;
  localparam logic [1:0] PC_INC     = 2'b10;
  localparam logic [1:0] PC_JUMP    = 2'b11;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_CMP = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JEQ = 4'hB;
  localparam logic [3:0] OP_JGT = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Flag bit positions as produced by the ALU on CMP.
  localparam int FLAG_EQ  = 0;
  localparam int FLAG_GRT = 1;

  // Conditional branches look at the flags register as it stands in EX,
  // so a CMP that retired one instruction earlier is already visible.
  function automatic logic branch_taken(input logic [3:0] op,
                                        input logic [7:0] flags);
    logic taken;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JEQ:  taken = flags[FLAG_EQ];
      OP_JGT:  taken = flags[FLAG_GRT];
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Opcodes whose result comes back from the ALU into R[rd].
  function automatic logic is_alu_write(input logic [3:0] op);
    logic wr;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: wr = 1'b1;
      default:                                      wr = 1'b0;
    endcase
    return wr;
  endfunction

  // Architectural state
  state_t      state_r;
  logic [7:0]  regs_r [4];
  logic [7:0]  flags_r;
  logic [7:0]  ir_r;
  logic [7:0]  k_r;
  logic        halted_r;

  // Decode of the latched instruction
  logic [3:0]  opcode_s;
  logic [1:0]  rd_s;
  logic [1:0]  rs_s;
  logic [7:0]  rd_val_s;
  logic [7:0]  rs_val_s;
  logic [15:0] data_addr_s;

  // Next-state / control
  state_t      state_nxt_s;
  logic [1:0]  pc_op_s;
  logic [15:0] mem_addr_s;
  logic        mem_rw_s;
  logic [3:0]  alu_op_s;
  logic        reg_we_s;
  logic [7:0]  reg_wdata_s;
  logic        flags_we_s;

  assign opcode_s    = ir_r[7:4];
  assign rd_s        = ir_r[3:2];
  assign rs_s        = ir_r[1:0];
  assign rd_val_s    = regs_r[rd_s];
  assign rs_val_s    = regs_r[rs_s];
  assign data_addr_s = {DATA_PAGE, k_r};

  // Sequencer: next state plus every control output, defaults first.
  always_comb begin
    state_nxt_s = state_r;
    pc_op_s     = PC_NOTHING;
    mem_addr_s  = bus.pc_addr;
    mem_rw_s    = 1'b0;
    alu_op_s    = OP_ADD;
    reg_we_s    = 1'b0;
    reg_wdata_s = bus.alu_c;
    flags_we_s  = 1'b0;

    case (state_r)
      ST_F0: begin
        // Address byte0; mem_q carries it during F1.
        state_nxt_s = ST_F1;
      end

      ST_F1: begin
        // 16-bit add wraps naturally, so FFFF fetches byte1 from 0000.
        mem_addr_s  = bus.pc_addr + 16'd1;
        state_nxt_s = ST_F2;
      end

      ST_F2: begin
        state_nxt_s = ST_EX;
      end

      ST_EX: begin
        state_nxt_s = ST_F0;
        pc_op_s     = PC_INC;
        case (opcode_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            alu_op_s    = opcode_s;
            reg_we_s    = is_alu_write(opcode_s);
            reg_wdata_s = bus.alu_c;
          end
          OP_CMP: begin
            alu_op_s   = OP_CMP;
            flags_we_s = 1'b1;
          end
          OP_LDI: begin
            reg_we_s    = 1'b1;
            reg_wdata_s = k_r;
          end
          OP_LD: begin
            // PC advances now; the data byte is collected in LDW.
            mem_addr_s  = data_addr_s;
            state_nxt_s = ST_LDW;
          end
          OP_ST: begin
            mem_addr_s = data_addr_s;
            mem_rw_s   = 1'b1;
          end
          OP_JMP, OP_JEQ, OP_JGT: begin
            if (branch_taken(opcode_s, flags_r)) begin
              pc_op_s = PC_JUMP;
            end else begin
              pc_op_s = PC_INC;
            end
          end
          OP_HLT: begin
            state_nxt_s = ST_HALT;
          end
          default: begin
            // D and E are NOPs: only the PC moves.
            pc_op_s = PC_INC;
          end
        endcase
      end

      ST_LDW: begin
        reg_we_s    = 1'b1;
        reg_wdata_s = bus.mem_q;
        state_nxt_s = ST_F0;
      end

      ST_HALT: begin
        // Absorbing; only reset leaves this state.
        state_nxt_s = ST_HALT;
      end

      default: begin
        state_nxt_s = ST_F0;
      end
    endcase
  end

  // While reset is held the PC is cleared and no write can reach memory,
  // even if the sequencer was caught in the EX cycle of a store.
  assign bus.pc_op     = rst_n ? pc_op_s  : PC_RESET;
  assign bus.mem_rw    = rst_n ? mem_rw_s : 1'b0;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_data  = rs_val_s;
  assign bus.pc_k      = k_r;
  assign bus.alu_op    = alu_op_s;
  assign bus.alu_a     = rd_val_s;
  assign bus.alu_b     = rs_val_s;
  assign bus.alu_flags = flags_r;
  assign halted        = halted_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_F0;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture byte0 at the end of F1 and k at the end of F2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_r <= 8'h00;
      k_r  <= 8'h00;
    end else begin
      if (state_r == ST_F1) begin
        ir_r <= bus.mem_q;
      end
      if (state_r == ST_F2) begin
        k_r <= bus.mem_q;
      end
    end
  end

  // Register file write port; operands were read combinationally before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (reg_we_s) begin
      regs_r[rd_s] <= reg_wdata_s;
    end
  end

  // Flags register, only written by CMP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_r <= 8'h00;
    end else if (flags_we_s) begin
      flags_r <= bus.alu_new_flags;
    end
  end

  // Halted flag rises on the edge that ends the EX of HLT and stays up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_r <= 1'b0;
    end else if ((state_r == ST_EX) && (opcode_s == OP_HLT)) begin
      halted_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: models pc, a 64K byte memory and the ALU around the
// sequencer, runs small programs and scoreboards every memory write.
module tb_cpu_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  always #5 clk = ~clk;

  cpu_ctrl_if bus ();

  cpu_ctrl #(.DATA_PAGE(8'h00)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .halted (halted)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- environment models ----------------
  logic [15:0] pc_r;
  logic [15:0] pc_reset_val = 16'h0000;
  logic [7:0]  mem_b [65536];
  logic        tb_we   = 1'b0;
  logic [15:0] tb_addr = 16'h0000;
  logic [7:0]  tb_data = 8'h00;

  // Program counter: offsets count 2-byte instructions, bit7 = backward.
  always @(posedge clk) begin
    case (bus.pc_op)
      2'b00:   pc_r <= pc_reset_val;
      2'b10:   pc_r <= pc_r + 16'd2;
      2'b11:   pc_r <= bus.pc_k[7] ? pc_r - {8'd0, bus.pc_k[6:0], 1'b0}
                                   : pc_r + {8'd0, bus.pc_k[6:0], 1'b0};
      default: pc_r <= pc_r;
    endcase
  end
  assign bus.pc_addr = pc_r;

  // Synchronous memory with registered read; bench loading has priority.
  always @(posedge clk) begin
    bus.mem_q <= mem_b[bus.mem_addr];
    if (tb_we) mem_b[tb_addr] <= tb_data;
    else if (bus.mem_rw === 1'b1) mem_b[bus.mem_addr] <= bus.mem_data;
  end

  // ALU
  always_comb begin
    bus.alu_new_flags = {6'd0, (bus.alu_a > bus.alu_b), (bus.alu_a == bus.alu_b)};
    case (bus.alu_op)
      4'd0:    bus.alu_c = bus.alu_a + bus.alu_b;
      4'd1:    bus.alu_c = bus.alu_a - bus.alu_b;
      4'd2:    bus.alu_c = bus.alu_a & bus.alu_b;
      4'd3:    bus.alu_c = bus.alu_a | bus.alu_b;
      4'd4:    bus.alu_c = bus.alu_a ^ bus.alu_b;
      4'd5:    bus.alu_c = ~bus.alu_a;
      default: bus.alu_c = 8'h00;
    endcase
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t exp_q[$];
  wr_t w_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Every write cycle must match the next expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_rw === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: actual addr %h data %h, required no write",
                 bus.mem_addr, bus.mem_data);
      end else begin
        w_m = exp_q.pop_front();
        chk("write_addr", {16'd0, bus.mem_addr}, {16'd0, w_m.addr});
        chk("write_data", {24'd0, bus.mem_data}, {24'd0, w_m.data});
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic put(input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b1);
    poke(a, b0);
    poke(a + 16'd1, b1);
  endtask

  task automatic assert_reset(input int n);
    @(posedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_pc_op", {30'd0, bus.pc_op}, 32'd0);
      chk("rst_mem_rw", {31'd0, bus.mem_rw}, 32'd0);
      if (i < n - 1) @(posedge clk);
    end
  endtask

  // Release just after an edge so the next negedge belongs to cycle 1 (F0).
  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int limit, output int c);
    c = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (halted === 1'b1) begin
        c = i;
        break;
      end
    end
    if (c == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL halt_timeout: actual not halted after %0d cycles, required halted", limit);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_r;
    logic [7:0] exp_f;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int c;
    vecs[0] = '{4'h0, 8'h05, 8'h03, 8'h08, 8'h00};  // ADD
    vecs[1] = '{4'h0, 8'hFF, 8'h02, 8'h01, 8'h00};  // ADD wrap
    vecs[2] = '{4'h1, 8'h05, 8'h07, 8'hFE, 8'h00};  // SUB
    vecs[3] = '{4'h2, 8'hF0, 8'h3C, 8'h30, 8'h00};  // AND
    vecs[4] = '{4'h3, 8'hF0, 8'h0F, 8'hFF, 8'h00};  // OR
    vecs[5] = '{4'h4, 8'hAA, 8'hFF, 8'h55, 8'h00};  // XOR
    vecs[6] = '{4'h5, 8'h5A, 8'h33, 8'hA5, 8'h00};  // NOT
    vecs[7] = '{4'h6, 8'h07, 8'h07, 8'h07, 8'h01};  // CMP equal
    vecs[8] = '{4'h6, 8'h07, 8'h06, 8'h07, 8'h02};  // CMP greater
    vecs[9] = '{4'h6, 8'h06, 8'h07, 8'h06, 8'h00};  // CMP less

    // LDI R0,a ; LDI R1,b ; OP R0,R1 ; ST R0->0x80 ; HLT  (5 x 4 cycles)
    for (int v = 0; v < 10; v++) begin
      put(16'h0000, 8'h70, vecs[v].a);
      put(16'h0002, 8'h74, vecs[v].b);
      put(16'h0004, {vecs[v].op, 4'b0001}, 8'h00);
      put(16'h0006, 8'h90, 8'h80);
      put(16'h0008, 8'hF0, 8'h00);
      expect_wr(16'h0080, vecs[v].exp_r);
      assert_reset(2);
      release_reset();
      wait_halt(40, c);
      chk($sformatf("vec%0d_cycles", v), c, 32'd21);
      chk($sformatf("vec%0d_flags", v), {24'd0, bus.alu_flags}, {24'd0, vecs[v].exp_f});
      chk($sformatf("vec%0d_writes_left", v), exp_q.size(), 32'd0);
    end

    // Reset in the middle of a running loop clears registers and flags.
    put(16'h0000, 8'h70, 8'h11);   // LDI R0,11
    put(16'h0002, 8'h7C, 8'h33);   // LDI R3,33
    put(16'h0004, 8'h6C, 8'h00);   // CMP R3,R0 -> GRT
    put(16'h0006, 8'hA0, 8'h00);   // JMP to itself
    assert_reset(2);
    release_reset();
    repeat (30) @(negedge clk);
    chk("loop_flags", {24'd0, bus.alu_flags}, 32'h02);
    assert_reset(3);
    put(16'h0000, 8'h90, 8'h81);   // ST R0
    put(16'h0002, 8'h93, 8'h82);   // ST R3
    put(16'h0004, 8'hF0, 8'h00);
    release_reset();
    expect_wr(16'h0081, 8'h00);
    expect_wr(16'h0082, 8'h00);
    @(negedge clk);
    chk("first_fetch_addr", {16'd0, bus.mem_addr}, 32'h0000);
    chk("reset_flags", {24'd0, bus.alu_flags}, 32'h00);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    wait_halt(30, c);
    chk("reset_prog_cycles", c, 32'd12);
    chk("reset_writes_left", exp_q.size(), 32'd0);

    // CMP at 0x10 then JEQ back one instruction: taken (t=0) / not taken (t=1).
    for (int t = 0; t < 2; t++) begin
      put(16'h0000, 8'h70, 8'h07);
      put(16'h0002, 8'h74, (t == 0) ? 8'h07 : 8'h06);
      for (int i = 4; i < 16; i += 2) put(16'(i), 8'hD0, 8'h00);
      put(16'h0010, 8'h61, 8'h00);
      put(16'h0012, 8'hB0, 8'h81);
      put(16'h0014, 8'hF0, 8'h00);
      assert_reset(2);
      release_reset();
      repeat (40) @(negedge clk);   // EX of JEQ
      chk($sformatf("br%0d_pc_op", t), {30'd0, bus.pc_op}, (t == 0) ? 32'd3 : 32'd2);
      chk($sformatf("br%0d_pc_k", t), {24'd0, bus.pc_k}, 32'h81);
      @(negedge clk);               // following F0
      chk($sformatf("br%0d_next_fetch", t), {16'd0, bus.mem_addr}, (t == 0) ? 32'h10 : 32'h14);
      chk($sformatf("br%0d_flags", t), {24'd0, bus.alu_flags}, (t == 0) ? 32'h01 : 32'h02);
      if (t == 1) begin
        wait_halt(10, c);
        chk("br1_halt_cycles", c, 32'd4);
      end
    end

    // ST / LD round trip through page 00.
    poke(16'h0040, 8'h00);
    poke(16'h0041, 8'h00);
    put(16'h0000, 8'h78, 8'hA5);   // LDI R2,A5
    put(16'h0002, 8'h92, 8'h40);   // ST R2 -> 0x40
    put(16'h0004, 8'h8C, 8'h40);   // LD R3 <- 0x40
    put(16'h0006, 8'h93, 8'h41);   // ST R3 -> 0x41
    put(16'h0008, 8'hF0, 8'h00);
    expect_wr(16'h0040, 8'hA5);
    expect_wr(16'h0041, 8'hA5);
    assert_reset(2);
    release_reset();
    repeat (8) @(negedge clk);
    chk("st_ex_rw", {31'd0, bus.mem_rw}, 32'd1);
    @(negedge clk);
    chk("st_after_rw", {31'd0, bus.mem_rw}, 32'd0);
    repeat (3) @(negedge clk);     // EX of LD
    chk("ld_ex_addr", {16'd0, bus.mem_addr}, 32'h0040);
    chk("ld_ex_pc_op", {30'd0, bus.pc_op}, 32'd2);
    chk("ld_ex_rw", {31'd0, bus.mem_rw}, 32'd0);
    @(negedge clk);                // LDW
    chk("ldw_pc_op", {30'd0, bus.pc_op}, 32'd1);
    chk("ldw_pc_addr", {16'd0, bus.pc_addr}, 32'h0006);
    wait_halt(20, c);
    chk("stld_cycles", c, 32'd9);
    chk("stld_writes_left", exp_q.size(), 32'd0);

    // HLT: halted from cycle 5, then frozen.
    put(16'h0000, 8'hF0, 8'h00);
    assert_reset(2);
    release_reset();
    repeat (4) @(negedge clk);
    chk("hlt_ex_halted", {31'd0, halted}, 32'd0);
    chk("hlt_ex_pc_op", {30'd0, bus.pc_op}, 32'd2);
    @(negedge clk);
    chk("hlt_c5_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_hold", {13'd0, bus.pc_addr, bus.mem_rw, bus.pc_op}, {13'd0, 16'h0002, 1'b0, 2'b01});
    end
    assert_reset(2);
    release_reset();
    @(negedge clk);
    chk("unhalt_halted", {31'd0, halted}, 32'd0);
    chk("unhalt_fetch", {16'd0, bus.mem_addr}, 32'h0000);

    // Reset asserted exactly in the EX cycle of a store.
    poke(16'h0050, 8'h3C);
    put(16'h0000, 8'h78, 8'hA5);
    put(16'h0002, 8'h92, 8'h50);
    put(16'h0004, 8'hF0, 8'h00);
    assert_reset(2);
    release_reset();
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;               // now in EX of ST
    @(negedge clk);
    chk("stabort_rw", {31'd0, bus.mem_rw}, 32'd0);
    chk("stabort_pc_op", {30'd0, bus.pc_op}, 32'd0);
    release_reset();
    expect_wr(16'h0050, 8'hA5);
    @(negedge clk);
    chk("stabort_byte", {24'd0, mem_b[16'h0050]}, 32'h3C);
    chk("stabort_f0", {16'd0, bus.mem_addr}, 32'h0000);
    wait_halt(20, c);
    chk("stabort_cycles", c, 32'd12);
    chk("stabort_writes_left", exp_q.size(), 32'd0);

    // Instruction at FFFF takes its k byte from 0000.
    pc_reset_val = 16'hFFFF;
    poke(16'hFFFF, 8'h7C);         // LDI R3,99
    put(16'h0000, 8'h99, 8'h93);   // k=99 ; ST R3 ...
    put(16'h0002, 8'h60, 8'hF0);   // ... -> 0x60 ; HLT
    poke(16'h0004, 8'h00);
    expect_wr(16'h0060, 8'h99);
    assert_reset(2);
    release_reset();
    @(negedge clk);
    chk("wrap_f0_addr", {16'd0, bus.mem_addr}, 32'hFFFF);
    @(negedge clk);
    chk("wrap_f1_addr", {16'd0, bus.mem_addr}, 32'h0000);
    wait_halt(20, c);
    chk("wrap_cycles", c, 32'd11);
    chk("wrap_writes_left", exp_q.size(), 32'd0);
    pc_reset_val = 16'h0000;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1);
  end

endmodule
